// File: rtl/gol_pkg.sv
// Shared constants and types for the Game-of-Life cell update stage.
package gol_pkg;

    localparam int unsigned NEIGHBOURS_CNT = 8;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned SEL_W          = $clog2(NEIGHBOURS_CNT);
    localparam int unsigned MASK_W         = NEIGHBOURS_CNT + 1;

    // Read index 0..7 selects a neighbour, index 8 the centre cell.
    localparam logic [IDX_W-1:0] CENTRE_IDX = IDX_W'(NEIGHBOURS_CNT);

    localparam logic [MASK_W-1:0] DEFAULT_BIRTH_MASK   = 9'b000001000;
    localparam logic [MASK_W-1:0] DEFAULT_SURVIVE_MASK = 9'b000001100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } cns_state_t;

endpackage

// File: rtl/gol_rule.sv
// Combinational life rule: live-neighbour count + centre state + masks -> next state.
module gol_rule
    import gol_pkg::*;
(
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic              i_alive,
    input  logic [MASK_W-1:0] i_birth_mask,
    input  logic [MASK_W-1:0] i_survive_mask,
    output logic              o_next_state_c
);

    always_comb begin
        o_next_state_c = 1'b0;
        if (i_cnt < CNT_W'(MASK_W)) begin
            o_next_state_c = i_alive ? i_survive_mask[i_cnt] : i_birth_mask[i_cnt];
        end
    end

endmodule

// File: rtl/cell_next_state.sv
// Reads the relevant neighbours and the centre of one cell, counts live neighbours and
// returns the cell's next state over valid/ready. RULE_CFG_EN adds runtime birth/survive masks.
module cell_next_state
    import gol_pkg::*;
#(
    parameter  int unsigned FIELD_W    = 16,
    parameter  int unsigned FIELD_H    = 16,
    localparam int unsigned X_ADR_SIZE = $clog2(FIELD_W),
    localparam int unsigned Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [X_ADR_SIZE-1:0]     i_cell_x_adr,
    input  logic [Y_ADR_SIZE-1:0]     i_cell_y_adr,
    input  logic [X_ADR_SIZE-1:0]     i_nbrs_x_adr [NEIGHBOURS_CNT],
    input  logic [Y_ADR_SIZE-1:0]     i_nbrs_y_adr [NEIGHBOURS_CNT],
    input  logic [NEIGHBOURS_CNT-1:0] i_nbrs_rlvnt,
    output logic                      o_rd_en,
    output logic [X_ADR_SIZE-1:0]     o_rd_x_adr,
    output logic [Y_ADR_SIZE-1:0]     o_rd_y_adr,
    input  logic                      i_rd_data,
    output logic                      o_busy,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_next_state,
    output logic [CNT_W-1:0]          o_nbrs_alive
`ifdef RULE_CFG_EN
    ,
    input  logic [MASK_W-1:0]         i_birth_mask,
    input  logic [MASK_W-1:0]         i_survive_mask
`endif
);

    cns_state_t state_q, state_nxt;

    logic [IDX_W-1:0]          rd_idx_q, rd_idx_nxt;
    logic [X_ADR_SIZE-1:0]     cell_x_q;
    logic [Y_ADR_SIZE-1:0]     cell_y_q;
    logic [X_ADR_SIZE-1:0]     nbr_x_q [NEIGHBOURS_CNT];
    logic [Y_ADR_SIZE-1:0]     nbr_y_q [NEIGHBOURS_CNT];
    logic [NEIGHBOURS_CNT-1:0] rlvnt_q;

    logic                  rd_en_q, rd_en_nxt;
    logic                  rd_ctr_q, rd_ctr_nxt;
    logic [X_ADR_SIZE-1:0] rd_x_q, rd_x_nxt;
    logic [Y_ADR_SIZE-1:0] rd_y_q, rd_y_nxt;
    logic                  pend_q, pend_ctr_q;

    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             valid_q, valid_nxt;
    logic             next_q, next_nxt;
    logic [CNT_W-1:0] alive_q, alive_nxt;
    logic             busy_q;
    logic             accept_c;
    logic             rule_next_c;

    logic [MASK_W-1:0] birth_mask_c;
    logic [MASK_W-1:0] survive_mask_c;

`ifdef RULE_CFG_EN
    logic [MASK_W-1:0] birth_q, survive_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            birth_q   <= '0;
            survive_q <= '0;
        end else if (accept_c) begin
            birth_q   <= i_birth_mask;
            survive_q <= i_survive_mask;
        end
    end

    assign birth_mask_c   = birth_q;
    assign survive_mask_c = survive_q;
`else
    assign birth_mask_c   = DEFAULT_BIRTH_MASK;
    assign survive_mask_c = DEFAULT_SURVIVE_MASK;
`endif

    // Centre data is consumed straight from the memory in the DRAIN cycle it arrives.
    gol_rule u_rule (
        .i_cnt          (cnt_q),
        .i_alive        (i_rd_data),
        .i_birth_mask   (birth_mask_c),
        .i_survive_mask (survive_mask_c),
        .o_next_state_c (rule_next_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt  = state_q;
        rd_idx_nxt = rd_idx_q;
        rd_en_nxt  = 1'b0;
        rd_ctr_nxt = 1'b0;
        rd_x_nxt   = rd_x_q;
        rd_y_nxt   = rd_y_q;
        cnt_nxt    = cnt_q;
        valid_nxt  = valid_q;
        next_nxt   = next_q;
        alive_nxt  = alive_q;
        accept_c   = 1'b0;

        // Neighbour data returns two edges after its issue; pend_q marks an issued read.
        if (pend_q && !pend_ctr_q && i_rd_data) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    accept_c   = 1'b1;
                    state_nxt  = ISSUE;
                    rd_idx_nxt = '0;
                    cnt_nxt    = '0;
                end
            end
            ISSUE: begin
                if (rd_idx_q == CENTRE_IDX) begin
                    rd_en_nxt  = 1'b1;
                    rd_ctr_nxt = 1'b1;
                    rd_x_nxt   = cell_x_q;
                    rd_y_nxt   = cell_y_q;
                    state_nxt  = DRAIN;
                end else begin
                    rd_en_nxt  = rlvnt_q[rd_idx_q[SEL_W-1:0]];
                    rd_x_nxt   = nbr_x_q[rd_idx_q[SEL_W-1:0]];
                    rd_y_nxt   = nbr_y_q[rd_idx_q[SEL_W-1:0]];
                    rd_idx_nxt = rd_idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (pend_ctr_q) begin
                    state_nxt = OUT;
                    valid_nxt = 1'b1;
                    next_nxt  = rule_next_c;
                    alive_nxt = cnt_q;
                end
            end
            OUT: begin
                if (i_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_idx_q   <= '0;
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            rlvnt_q    <= '0;
            for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
                nbr_x_q[i] <= '0;
                nbr_y_q[i] <= '0;
            end
            rd_en_q    <= 1'b0;
            rd_ctr_q   <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            pend_q     <= 1'b0;
            pend_ctr_q <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            next_q     <= 1'b0;
            alive_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            rd_idx_q   <= rd_idx_nxt;
            rd_en_q    <= rd_en_nxt;
            rd_ctr_q   <= rd_ctr_nxt;
            rd_x_q     <= rd_x_nxt;
            rd_y_q     <= rd_y_nxt;
            pend_q     <= rd_en_q;
            pend_ctr_q <= rd_ctr_q;
            cnt_q      <= cnt_nxt;
            valid_q    <= valid_nxt;
            next_q     <= next_nxt;
            alive_q    <= alive_nxt;
            busy_q     <= (state_nxt != IDLE);
            if (accept_c) begin
                cell_x_q <= i_cell_x_adr;
                cell_y_q <= i_cell_y_adr;
                rlvnt_q  <= i_nbrs_rlvnt;
                nbr_x_q  <= i_nbrs_x_adr;
                nbr_y_q  <= i_nbrs_y_adr;
            end
        end
    end

    assign o_rd_en      = rd_en_q;
    assign o_rd_x_adr   = rd_x_q;
    assign o_rd_y_adr   = rd_y_q;
    assign o_busy       = busy_q;
    assign o_valid      = valid_q;
    assign o_next_state = next_q;
    assign o_nbrs_alive = alive_q;

endmodule

// File: tb/tb_cell_next_state.sv
// Randomised self-checking bench for cell_next_state against a field-level life model.
// Builds with or without RULE_CFG_EN.
module tb_cell_next_state;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cell_x = '0;
    logic [3:0] cell_y = '0;
    logic [3:0] nbrs_x [8];
    logic [3:0] nbrs_y [8];
    logic [7:0] rlvnt = '0;
    logic       rd_en;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic       rd_data = 1'b0;
    logic       busy;
    logic       valid;
    logic       ready = 1'b0;
    logic       next_state;
    logic [3:0] nbrs_alive;
`ifdef RULE_CFG_EN
    logic [8:0] birth_mask   = 9'b000001000;
    logic [8:0] survive_mask = 9'b000001100;
`endif

    bit mem [16][16];
    int m_nx [8];
    int m_ny [8];
    int n_checks = 0;
    int n_fail   = 0;

    cell_next_state #(.FIELD_W(16), .FIELD_H(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_cell_x_adr (cell_x),
        .i_cell_y_adr (cell_y),
        .i_nbrs_x_adr (nbrs_x),
        .i_nbrs_y_adr (nbrs_y),
        .i_nbrs_rlvnt (rlvnt),
        .o_rd_en      (rd_en),
        .o_rd_x_adr   (rd_x),
        .o_rd_y_adr   (rd_y),
        .i_rd_data    (rd_data),
        .o_busy       (busy),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_next_state (next_state),
        .o_nbrs_alive (nbrs_alive)
`ifdef RULE_CFG_EN
        ,
        .i_birth_mask   (birth_mask),
        .i_survive_mask (survive_mask)
`endif
    );

    always #5 clk = ~clk;

    // Field memory: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_y][rd_x];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_next(input int alive, input int cnt);
`ifdef RULE_CFG_EN
        return alive != 0 ? int'(survive_mask[cnt]) : int'(birth_mask[cnt]);
`else
        if (alive != 0) return (cnt == 2 || cnt == 3) ? 1 : 0;
        return (cnt == 3) ? 1 : 0;
`endif
    endfunction

    // Neighbour order: row above left-to-right, left, right, row below left-to-right.
    task automatic set_nbrs(input int cx, input int cy);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (i < 4) ? i : i + 1;
            m_nx[i] = (cx + (k % 3) - 1 + 16) % 16;
            m_ny[i] = (cy + (k / 3) - 1 + 16) % 16;
        end
    endtask

    task automatic clear_mem(input bit v);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                mem[y][x] = v;
    endtask

    task automatic scramble_inputs();
        cell_x = 4'($urandom);
        cell_y = 4'($urandom);
        rlvnt  = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            nbrs_x[i] = 4'($urandom);
            nbrs_y[i] = 4'($urandom);
        end
    endtask

    // One full transaction; called at #1 after a rising edge.
    task automatic run_cell(input int cx, input int cy, input logic [7:0] rl,
                            input int hold, input string tag);
        int         exp_cnt;
        int         exp_next;
        int         edges;
        int         held_cnt;
        int         held_next;
        logic [7:0] exp_reads [$];
        logic [7:0] reads [$];

        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (rl[i]) begin
                exp_cnt += int'(mem[m_ny[i]][m_nx[i]]);
                exp_reads.push_back({4'(m_ny[i]), 4'(m_nx[i])});
            end
        end
        exp_reads.push_back({4'(cy), 4'(cx)});
        exp_next = model_next(int'(mem[cy][cx]), exp_cnt);

        check_eq({tag, "_idle_busy"}, int'(busy), 0);
        cell_x = 4'(cx);
        cell_y = 4'(cy);
        rlvnt  = rl;
        for (int i = 0; i < 8; i++) begin
            nbrs_x[i] = 4'(m_nx[i]);
            nbrs_y[i] = 4'(m_ny[i]);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();

        edges = 0;
        while (!valid && edges < 20) begin
            if (rd_en) reads.push_back({rd_y, rd_x});
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq({tag, "_latency"}, edges, 11);
        check_eq({tag, "_count"}, int'(nbrs_alive), exp_cnt);
        check_eq({tag, "_next"}, int'(next_state), exp_next);
        check_eq({tag, "_nreads"}, reads.size(), exp_reads.size());
        if (reads.size() == exp_reads.size()) begin
            for (int i = 0; i < reads.size(); i++)
                check_eq({tag, "_read_adr"}, int'(reads[i]), int'(exp_reads[i]));
        end

        held_cnt  = int'(nbrs_alive);
        held_next = int'(next_state);
        for (int k = 0; k < hold; k++) begin
            start = 1'b1;
            scramble_inputs();
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, int'(valid), 1);
            check_eq({tag, "_hold_busy"}, int'(busy), 1);
            check_eq({tag, "_hold_count"}, int'(nbrs_alive), held_cnt);
            check_eq({tag, "_hold_next"}, int'(next_state), held_next);
        end

        ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        start = 1'b0;
        check_eq({tag, "_done_valid"}, int'(valid), 0);
        check_eq({tag, "_done_busy"}, int'(busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_en"}, int'(rd_en), 0);
        check_eq({tag, "_rd_x"}, int'(rd_x), 0);
        check_eq({tag, "_rd_y"}, int'(rd_y), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_valid"}, int'(valid), 0);
        check_eq({tag, "_next"}, int'(next_state), 0);
        check_eq({tag, "_count"}, int'(nbrs_alive), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            nbrs_x[i] = '0;
            nbrs_y[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Centre (5,5) alive with three live cells in the row above.
        clear_mem(1'b0);
        mem[5][5] = 1'b1;
        mem[4][4] = 1'b1;
        mem[4][5] = 1'b1;
        mem[4][6] = 1'b1;
        set_nbrs(5, 5);
        run_cell(5, 5, 8'hFF, 5, "centre55");

        // Corner cell, only neighbours 4, 6, 7 inside the field.
        clear_mem(1'b1);
        set_nbrs(0, 0);
        run_cell(0, 0, 8'b1101_0000, 0, "corner");

        clear_mem(1'b0);
        mem[8][8] = 1'b1;
        mem[8][9] = 1'b1;
        set_nbrs(8, 8);
        run_cell(8, 8, 8'hFF, 1, "lonely");

        clear_mem(1'b0);
        mem[2][9]  = 1'b1;
        mem[4][11] = 1'b1;
        mem[4][10] = 1'b1;
        set_nbrs(10, 3);
        run_cell(10, 3, 8'hFF, 0, "birth");

        clear_mem(1'b0);
        set_nbrs(12, 12);
        mem[12][12] = 1'b1;
        for (int i = 0; i < 8; i++) mem[m_ny[i]][m_nx[i]] = 1'b1;
        run_cell(12, 12, 8'hFF, 2, "crowded");

        // Reset while the fifth neighbour read is being issued.
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                mem[y][x] = 1'($urandom);
        set_nbrs(7, 9);
        cell_x = 4'd7;
        cell_y = 4'd9;
        rlvnt  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            nbrs_x[i] = 4'(m_nx[i]);
            nbrs_y[i] = 4'(m_ny[i]);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_cell(7, 9, 8'hFF, 2, "post_rst");

        for (int t = 0; t < 25; t++) begin
            int cx;
            int cy;
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    mem[y][x] = 1'($urandom);
            cx = int'($urandom_range(0, 15));
            cy = int'($urandom_range(0, 15));
            set_nbrs(cx, cy);
`ifdef RULE_CFG_EN
            birth_mask   = 9'($urandom);
            survive_mask = 9'($urandom);
`endif
            run_cell(cx, cy, 8'($urandom), int'($urandom_range(0, 3)), "rand");
        end

`ifdef RULE_CFG_EN
        birth_mask   = 9'b000000100;
        survive_mask = 9'b000000000;
        clear_mem(1'b0);
        set_nbrs(3, 3);
        mem[m_ny[0]][m_nx[0]] = 1'b1;
        mem[m_ny[7]][m_nx[7]] = 1'b1;
        run_cell(3, 3, 8'hFF, 0, "cfg_dead2");
        mem[3][3] = 1'b1;
        run_cell(3, 3, 8'hFF, 0, "cfg_alive2");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
